// File: rtl/tie_bank_pkg.sv
// Shared types and constants for the programmable tie bank.
// TIE_BANK_PARITY_EN adds one trailing even-parity bit to every serial word.
package tie_bank_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FULL   = 2'd2,
        LOCKED = 2'd3
    } tie_state_e;

`ifdef TIE_BANK_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tie_cfg_shifter.sv
// Serial configuration front end: shadow word, bit counter and (with
// TIE_BANK_PARITY_EN) a separate register for the trailing parity bit.
module tie_cfg_shifter
    import tie_bank_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_shift,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_shadow,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_full,
    output logic             o_par_ok
);

    localparam int NBITS = WIDTH + PAR_BITS;

    logic [WIDTH-1:0] r_shadow;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_shift_val;
    logic             w_data_bit;

    // New bits enter at the MSB so the first bit received ends up in bit 0.
    assign w_shift_val = (r_shadow >> 1) | (WIDTH'(i_bit) << (WIDTH - 1));
    assign w_data_bit  = (r_cnt < CNT_W'(WIDTH));

    always_ff @(posedge ck) begin
        if (rst || i_clear) begin
            r_shadow <= '0;
            r_cnt    <= '0;
        end else if (i_shift) begin
            if (w_data_bit) r_shadow <= w_shift_val;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

`ifdef TIE_BANK_PARITY_EN
    logic r_parity;

    always_ff @(posedge ck) begin
        if (rst || i_clear) begin
            r_parity <= 1'b0;
        end else if (i_shift && !w_data_bit) begin
            r_parity <= i_bit;
        end
    end

    assign o_par_ok = (r_parity == ^r_shadow);
`else
    assign o_par_ok = 1'b1;
`endif

    assign o_shadow = r_shadow;
    assign o_cnt    = r_cnt;
    assign o_full   = (r_cnt == CNT_W'(NBITS));

endmodule

// File: rtl/tie_bank.sv
// Bank of WIDTH registered tie outputs, reprogrammable over a serial port
// until a one-way lock. Optional parity check via TIE_BANK_PARITY_EN.
module tie_bank
    import tie_bank_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_data,
    input  logic             commit,
    input  logic             lock,
    output logic [WIDTH-1:0] tie,
    output logic             busy,
    output logic             locked,
    output logic             err,
    output tie_state_e       dbg_state
);

    localparam int NBITS = WIDTH + PAR_BITS;
    localparam int CNT_W = clog2(WIDTH + 2);

    tie_state_e       r_state;
    tie_state_e       w_next_state;
    logic [WIDTH-1:0] r_tie;
    logic             r_err;

    logic             w_clear;
    logic             w_shift;
    logic             w_load;
    logic             w_err_next;
    logic [WIDTH-1:0] w_shadow;
    logic [CNT_W-1:0] w_cnt;
    logic             w_full;
    logic             w_par_ok;

    tie_cfg_shifter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shifter (
        .ck       (ck),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_shift  (w_shift),
        .i_bit    (cfg_data),
        .o_shadow (w_shadow),
        .o_cnt    (w_cnt),
        .o_full   (w_full),
        .o_par_ok (w_par_ok)
    );

    always_ff @(posedge ck) begin
        if (rst) begin
            r_state <= IDLE;
            r_tie   <= RESET_VAL;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_err   <= w_err_next;
            if (w_load) r_tie <= w_shadow;
        end
    end

    // Priority in IDLE/SHIFT: lock, then early commit, then a transfer.
    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_shift      = 1'b0;
        w_load       = 1'b0;
        w_err_next   = 1'b0;
        case (r_state)
            IDLE, SHIFT: begin
                if (lock) begin
                    w_clear      = 1'b1;
                    w_next_state = LOCKED;
                end else if (commit && (r_state == SHIFT)) begin
                    w_clear      = 1'b1;
                    w_err_next   = 1'b1;
                    w_next_state = IDLE;
                end else if (cfg_valid) begin
                    w_shift      = 1'b1;
                    w_next_state = (w_cnt == CNT_W'(NBITS - 1)) ? FULL : SHIFT;
                end
            end
            FULL: begin
                if (commit) begin
                    w_clear      = 1'b1;
                    w_load       = w_par_ok;
                    w_err_next   = !w_par_ok;
                    w_next_state = lock ? LOCKED : IDLE;
                end else if (lock) begin
                    w_clear      = 1'b1;
                    w_next_state = LOCKED;
                end
            end
            LOCKED: begin
                w_next_state = LOCKED;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign tie       = r_tie;
    assign err       = r_err;
    assign busy      = (r_state == SHIFT);
    assign locked    = (r_state == LOCKED);
    assign cfg_ready = ((r_state == IDLE) || (r_state == SHIFT)) && !w_full;
    assign dbg_state = r_state;

endmodule
